// File: rtl/mac_psum_accum.sv
// mac_psum_accum
//   Downstream stage of a MAC processing-element column. Accumulates the
//   unsigned partial sums leaving the bottom PE across K-tiles into a
//   saturating ACC_W-bit result. Completed results are queued in a small
//   FIFO and drained to writeback over a valid/ready handshake.
//
// Ports
//   clock       single clock, all state on the rising edge
//   reset       asynchronous, active-low reset
//   clear       synchronous soft clear (flushes accumulation, FIFO, seq_err)
//   psum_in     partial sum from the PE column (IN_W, unsigned)
//   psum_valid  psum_in beat valid
//   psum_first  beat starts a new accumulation
//   psum_last   beat ends the accumulation
//   psum_ready  stage can accept a beat (FIFO not full, out of reset)
//   out_data    accumulated result at the FIFO head (ACC_W)
//   out_beats   number of beats summed into out_data (CNT_W, saturating)
//   out_ovf     out_data saturated
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts the head entry
//   seq_err     sticky first/last framing-error flag
module mac_psum_accum #(
  parameter int IN_W       = 24,
  parameter int ACC_W      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [IN_W-1:0]  psum_in,
  input  logic             psum_valid,
  input  logic             psum_first,
  input  logic             psum_last,
  output logic             psum_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             seq_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  // Accumulator control state
  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             seq_err_q, seq_err_d;

  // FIFO state
  logic [ACC_W-1:0] mem_data_q  [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_beats_q [FIFO_DEPTH];
  logic             mem_ovf_q   [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;

  logic             accept;
  logic             push, push_en, pop_en;
  logic [ACC_W-1:0] push_data;
  logic [CNT_W-1:0] push_beats;
  logic             push_ovf;

  logic [ACC_W-1:0] psum_ext;
  logic [ACC_W:0]   sum_wide;
  logic             sum_ovf;
  logic [ACC_W-1:0] sum_res;
  logic [CNT_W-1:0] cnt_inc;

  // psum_ready is gated by reset so it reads 0 while reset is held
  assign psum_ready = reset & (count_q < DEPTH_C);
  assign accept     = psum_valid & psum_ready;
  assign out_valid  = (count_q != '0);

  // One extra bit catches the carry out; a carry means the result clamps
  assign psum_ext = {{(ACC_W-IN_W){1'b0}}, psum_in};
  assign sum_wide = {1'b0, acc_q} + {1'b0, psum_ext};
  assign sum_ovf  = sum_wide[ACC_W];
  assign sum_res  = sum_ovf ? ACC_MAX : sum_wide[ACC_W-1:0];
  assign cnt_inc  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    seq_err_d  = seq_err_q;
    push       = 1'b0;
    push_data  = '0;
    push_beats = '0;
    push_ovf   = 1'b0;
    if (accept) begin
      if (psum_first) begin
        // A first beat while accumulating abandons the open frame
        if (state_q == ACCUM) seq_err_d = 1'b1;
        if (psum_last) begin
          push       = 1'b1;
          push_data  = psum_ext;
          push_beats = CNT_ONE;
          state_d    = IDLE;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_d      = 1'b0;
        end else begin
          state_d = ACCUM;
          acc_d   = psum_ext;
          cnt_d   = CNT_ONE;
          ovf_d   = 1'b0;
        end
      end else if (state_q == IDLE) begin
        seq_err_d = 1'b1;
      end else if (psum_last) begin
        push       = 1'b1;
        push_data  = sum_res;
        push_beats = cnt_inc;
        push_ovf   = ovf_q | sum_ovf;
        state_d    = IDLE;
        acc_d      = '0;
        cnt_d      = '0;
        ovf_d      = 1'b0;
      end else begin
        acc_d = sum_res;
        cnt_d = cnt_inc;
        ovf_d = ovf_q | sum_ovf;
      end
    end
  end

  // push is only possible on an accepted beat, so never into a full FIFO
  assign push_en = push & ~clear;
  assign pop_en  = out_valid & out_ready & ~clear;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      seq_err_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else if (clear) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      seq_err_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      seq_err_q <= seq_err_d;
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the head is masked whenever the FIFO is empty
  always_ff @(posedge clock) begin
    if (push_en) begin
      mem_data_q[wr_ptr_q]  <= push_data;
      mem_beats_q[wr_ptr_q] <= push_beats;
      mem_ovf_q[wr_ptr_q]   <= push_ovf;
    end
  end

  assign out_data  = out_valid ? mem_data_q[rd_ptr_q]  : '0;
  assign out_beats = out_valid ? mem_beats_q[rd_ptr_q] : '0;
  assign out_ovf   = out_valid ? mem_ovf_q[rd_ptr_q]   : 1'b0;
  assign seq_err   = seq_err_q;

endmodule
